// File: rtl/hash_steer.sv
// Per-packet flow steering: fold the packet hash to a destination index, then forward the
// packet's beats through a one-entry output register to exactly one of NUM_DST queues.
// Also keeps a free-running 32-bit packet counter per destination.
module hash_steer #(
  parameter int unsigned DATA_W        = 512,
  parameter int unsigned PADBYTES_W    = $clog2(DATA_W / 8),
  parameter int unsigned NUM_DST       = 4,
  parameter int unsigned DST_W         = (NUM_DST > 1) ? $clog2(NUM_DST) : 1,
  parameter int unsigned DEFAULT_DST   = 0,
  parameter int unsigned HASH_STRUCT_W = 96
) (
  input  logic                    clk,
  input  logic                    rst,
  // Metadata record
  input  logic                    parser_steer_meta_val,
  input  logic                    parser_steer_hash_val,
  input  logic [HASH_STRUCT_W-1:0] parser_steer_hash_data,
  output logic                    steer_parser_meta_rdy,
  // Input beats
  input  logic                    parser_steer_data_val,
  input  logic [DATA_W-1:0]       parser_steer_data,
  input  logic [PADBYTES_W-1:0]   parser_steer_padbytes,
  input  logic                    parser_steer_last,
  output logic                    steer_parser_data_rdy,
  // Output beats, shared bus with one-hot valid
  output logic [NUM_DST-1:0]      steer_dst_data_val,
  output logic [DATA_W-1:0]       steer_dst_data,
  output logic [PADBYTES_W-1:0]   steer_dst_padbytes,
  output logic                    steer_dst_last,
  input  logic [NUM_DST-1:0]      dst_steer_data_rdy,
  // Debug counters
  output logic [NUM_DST*32-1:0]   steer_pkt_cnt
);

  localparam int unsigned NumWords = (HASH_STRUCT_W + 31) / 32;
  localparam int unsigned PadW     = NumWords * 32;

  typedef enum logic [0:0] {StIdle, StData} state_e;

  state_e                  state_q;
  logic [DST_W-1:0]        cur_dst_q;
  logic [DST_W-1:0]        meta_dst;
  logic [PadW-1:0]         hash_pad;
  logic [31:0]             fold;

  logic                    out_val_q;
  logic [DST_W-1:0]        out_dst_q;
  logic [DATA_W-1:0]       out_data_q;
  logic [PADBYTES_W-1:0]   out_pad_q;
  logic                    out_last_q;
  logic                    out_dst_rdy;
  logic                    beat_acc;
  logic                    pkt_done;

  logic [NUM_DST*32-1:0]   cnt_q;
  logic [NUM_DST*32-1:0]   cnt_d;

  assign hash_pad = PadW'(parser_steer_hash_data);

  // XOR-fold the zero-padded hash record into one 32-bit word
  always_comb begin
    fold = '0;
    for (int unsigned w = 0; w < NumWords; w++) begin
      fold = fold ^ hash_pad[32*w +: 32];
    end
  end

  // Destination for the record currently offered on the metadata port
  always_comb begin
    meta_dst = '0;
    if (NUM_DST > 1) begin
      meta_dst = parser_steer_hash_val ? fold[DST_W-1:0] : DST_W'(DEFAULT_DST);
    end
  end

  assign out_dst_rdy           = dst_steer_data_rdy[out_dst_q];
  assign steer_parser_meta_rdy = (state_q == StIdle);
  // A beat may enter whenever the output register is empty or is draining this cycle
  assign steer_parser_data_rdy = (state_q == StData) && (!out_val_q || out_dst_rdy);
  assign beat_acc              = parser_steer_data_val && steer_parser_data_rdy;
  assign pkt_done              = beat_acc && parser_steer_last;

  // Packet-level FSM: latch the destination from metadata, return to idle on the last beat
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cur_dst_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (parser_steer_meta_val) begin
            cur_dst_q <= meta_dst;
            state_q   <= StData;
          end
        end
        StData: begin
          if (pkt_done) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // One-entry output register; destination is stored per beat so a held last beat
  // of one packet does not block metadata for the next
  always_ff @(posedge clk) begin
    if (rst) begin
      out_val_q  <= 1'b0;
      out_dst_q  <= '0;
      out_data_q <= '0;
      out_pad_q  <= '0;
      out_last_q <= 1'b0;
    end else if (beat_acc) begin
      out_val_q  <= 1'b1;
      out_dst_q  <= cur_dst_q;
      out_data_q <= parser_steer_data;
      out_pad_q  <= parser_steer_padbytes;
      out_last_q <= parser_steer_last;
    end else if (out_val_q && out_dst_rdy) begin
      out_val_q  <= 1'b0;
    end
  end

  // Decode the stored destination onto the one-hot valid
  always_comb begin
    steer_dst_data_val = '0;
    if (out_val_q) steer_dst_data_val[out_dst_q] = 1'b1;
  end

  assign steer_dst_data     = out_data_q;
  assign steer_dst_padbytes = out_pad_q;
  assign steer_dst_last     = out_last_q;

  // Count packets when their last beat is accepted at the input
  always_comb begin
    cnt_d = cnt_q;
    if (pkt_done) begin
      cnt_d[32*cur_dst_q +: 32] = cnt_q[32*cur_dst_q +: 32] + 32'd1;
    end
  end

  // Counter state
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign steer_pkt_cnt = cnt_q;

endmodule

// File: tb/tb_hash_steer.sv
// Self-checking bench for hash_steer: directed scenarios plus randomized packets, checked
// against a transaction-level model (bitwise hash fold, expected-beat queue, packet counts).
module tb_hash_steer;

  localparam int unsigned DW   = 512;
  localparam int unsigned PW   = 6;
  localparam int unsigned ND   = 4;
  localparam int unsigned DEF  = 0;
  localparam int unsigned HW   = 104;

  logic               clk;
  logic               rst;
  logic               meta_val;
  logic               hash_val;
  logic [HW-1:0]      hash_data;
  logic               meta_rdy;
  logic               data_val;
  logic [DW-1:0]      data;
  logic [PW-1:0]      pad;
  logic               last;
  logic               data_rdy;
  logic [ND-1:0]      o_val;
  logic [DW-1:0]      o_data;
  logic [PW-1:0]      o_pad;
  logic               o_last;
  logic [ND-1:0]      dst_rdy;
  logic [ND*32-1:0]   pkt_cnt;

  hash_steer #(
    .DATA_W       (DW),
    .PADBYTES_W   (PW),
    .NUM_DST      (ND),
    .DST_W        (2),
    .DEFAULT_DST  (DEF),
    .HASH_STRUCT_W(HW)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .parser_steer_meta_val (meta_val),
    .parser_steer_hash_val (hash_val),
    .parser_steer_hash_data(hash_data),
    .steer_parser_meta_rdy (meta_rdy),
    .parser_steer_data_val (data_val),
    .parser_steer_data     (data),
    .parser_steer_padbytes (pad),
    .parser_steer_last     (last),
    .steer_parser_data_rdy (data_rdy),
    .steer_dst_data_val    (o_val),
    .steer_dst_data        (o_data),
    .steer_dst_padbytes    (o_pad),
    .steer_dst_last        (o_last),
    .dst_steer_data_rdy    (dst_rdy),
    .steer_pkt_cnt         (pkt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned     dst;
    logic [DW-1:0]   data;
    logic [PW-1:0]   pad;
    logic            last;
  } beat_t;

  int          checks = 0;
  int          passes = 0;
  int          cyc = 0;
  beat_t       ob[$];          // beats accepted but not yet drained, in order
  bit          in_pkt = 0;     // metadata taken, last beat not yet taken
  int unsigned cur_m = 0;
  logic [31:0] cnt_m [ND];
  bit          acc_g;
  bit          meta_acc_g;
  int          rdy_mode = 0;   // 0 all ready, 1 random, 2 random except focus queue
  int unsigned focus = 0;
  int          st_lo = -1;
  int          st_hi = -1;
  logic [ND-1:0] st_mask = '0;
  bit          bubbles = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Destination from first principles: bit b of the record toggles fold bit b mod 32
  function automatic int unsigned model_dst(input bit hv, input logic [HW-1:0] h);
    logic [31:0] f;
    f = '0;
    if (!hv) return DEF;
    for (int b = 0; b < HW; b++) if (h[b]) f[b % 32] = ~f[b % 32];
    return f % ND;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int k = 0; k < DW / 32; k++) d[32*k +: 32] = $urandom;
    return d;
  endfunction

  function automatic logic [HW-1:0] rand_hash();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[HW-1:0];
  endfunction

  task automatic set_rdy();
    for (int i = 0; i < ND; i++) begin
      if (rdy_mode == 0) dst_rdy[i] = 1'b1;
      else dst_rdy[i] = ($urandom_range(0, 3) != 0);
    end
    if (rdy_mode == 2) dst_rdy[focus] = 1'b1;
    if (cyc >= st_lo && cyc < st_hi) dst_rdy = dst_rdy & ~st_mask;
  endtask

  // One clock: entered at a falling edge with inputs applied; checks, advances model
  task automatic cycle();
    logic [ND-1:0] exp_val;
    bit drain, exp_drdy, macc;
    cyc++;
    set_rdy();
    #1;
    acc_g = 0;
    meta_acc_g = 0;
    if (rst) begin
      ob.delete();
      in_pkt = 0;
      for (int i = 0; i < ND; i++) cnt_m[i] = '0;
    end else begin
      chk("meta_rdy", meta_rdy, !in_pkt);
      exp_val = '0;
      if (ob.size() > 0) exp_val[ob[0].dst] = 1'b1;
      chk("out_val", o_val, exp_val);
      if (ob.size() > 0) begin
        chk("out_data", o_data, ob[0].data);
        chk("out_pad", o_pad, ob[0].pad);
        chk("out_last", o_last, ob[0].last);
      end
      drain = (ob.size() > 0) && dst_rdy[ob[0].dst];
      exp_drdy = in_pkt && ((ob.size() == 0) || drain);
      chk("data_rdy", data_rdy, exp_drdy);
      for (int i = 0; i < ND; i++) chk($sformatf("cnt%0d", i), pkt_cnt[32*i +: 32], cnt_m[i]);
      macc = meta_val && !in_pkt;
      if (drain) void'(ob.pop_front());
      if (data_val && exp_drdy) begin
        acc_g = 1;
        ob.push_back('{dst: cur_m, data: data, pad: pad, last: last});
        if (last) begin
          cnt_m[cur_m] = cnt_m[cur_m] + 32'd1;
          in_pkt = 0;
        end
      end
      if (macc) begin
        meta_acc_g = 1;
        in_pkt = 1;
        cur_m = model_dst(hash_val, hash_data);
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    meta_val = 0;
    data_val = 0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic reset_checks();
    chk("rst_val", o_val, '0);
    chk("rst_data", o_data, '0);
    chk("rst_pad", o_pad, '0);
    chk("rst_last", o_last, 1'b0);
    chk("rst_cnt", pkt_cnt, '0);
    chk("rst_meta_rdy", meta_rdy, 1'b1);
    chk("rst_data_rdy", data_rdy, 1'b0);
  endtask

  // Send one packet; abort_after>0 returns once that many beats were accepted
  task automatic send_pkt(input bit hv, input logic [HW-1:0] h, input int nb,
                          input logic [PW-1:0] lpad, input int abort_after);
    int n;
    meta_val  = 1;
    hash_val  = hv;
    hash_data = h;
    data_val  = bubbles ? 1'($urandom_range(0, 1)) : 1'b0;  // must be ignored in idle
    data      = rand_data();
    last      = 1'b1;
    n = 0;
    do begin cycle(); n++; end while (!meta_acc_g && n < 50);
    chk("meta_accept", meta_acc_g, 1'b1);
    meta_val  = 0;
    hash_val  = 1'($urandom_range(0, 1));
    hash_data = rand_hash();
    for (int b = 0; b < nb; b++) begin
      data = rand_data();
      pad  = (b == nb - 1) ? lpad : PW'($urandom);
      last = (b == nb - 1);
      n = 0;
      do begin
        data_val = bubbles ? ($urandom_range(0, 4) != 0) : 1'b1;
        cycle();
        n++;
      end while (!acc_g && n < 200);
      chk("beat_accept", acc_g, 1'b1);
      data_val = 0;
      if (abort_after == b + 1) return;
    end
  endtask

  initial begin
    logic [HW-1:0] h;
    for (int i = 0; i < ND; i++) cnt_m[i] = '0;
    rst = 1; meta_val = 0; hash_val = 0; hash_data = '0;
    data_val = 0; data = '0; pad = '0; last = 0; dst_rdy = '1;
    @(negedge clk);
    cycle();
    cycle();
    rst = 0;
    #1;
    reset_checks();

    // Single packet: hash 5 folds to queue 1, three beats, last padbytes 10
    h = '0; h[31:0] = 32'h0000_0005;
    send_pkt(1'b1, h, 3, 6'd10, 0);
    idle(3);
    chk("t1_cnt1", pkt_cnt[63:32], 32'd1);

    // Invalid hash goes to the default queue
    send_pkt(1'b0, '1, 1, 6'd3, 0);
    idle(3);
    chk("t2_cnt0", pkt_cnt[31:0], 32'd1);

    // Backpressure on queue 2 for 5 cycles mid-packet; other ready bits random
    rdy_mode = 2; focus = 2;
    st_lo = cyc + 4; st_hi = cyc + 9; st_mask = 4'b0100;
    h = '0; h[95:64] = 32'h0000_0002;
    send_pkt(1'b1, h, 4, 6'd0, 0);
    idle(4);
    chk("t3_cnt2", pkt_cnt[95:64], 32'd1);
    rdy_mode = 0;

    // Packet A to queue 3 with last beat stalled, then packet B to queue 0
    st_lo = cyc + 3; st_hi = cyc + 10; st_mask = 4'b1000;
    h = '0; h[31:0] = 32'h0000_0003;
    send_pkt(1'b1, h, 2, 6'd7, 0);
    chk("t4_meta_rdy_held", meta_rdy, 1'b1);
    chk("t4_a_held", o_val, 4'b1000);
    h = '0; h[31:0] = 32'h0000_0004;
    send_pkt(1'b1, h, 3, 6'd1, 0);
    idle(4);
    chk("t4_cnt3", pkt_cnt[127:96], 32'd1);
    chk("t4_cnt0", pkt_cnt[31:0], 32'd2);
    st_lo = -1; st_hi = -1;

    // Counter wrap on queue 1
    force dut.cnt_q = {cnt_m[3], cnt_m[2], 32'hFFFF_FFFF, cnt_m[0]};
    cnt_m[1] = 32'hFFFF_FFFF;
    cycle();
    release dut.cnt_q;
    cycle();
    h = '0; h[63:32] = 32'h0000_0001;
    send_pkt(1'b1, h, 2, 6'd5, 0);
    idle(2);
    chk("t5_wrap", pkt_cnt[63:32], 32'd0);

    // Reset after beat 2 of 5, then a fresh packet
    h = '0; h[31:0] = 32'h0000_0002;
    send_pkt(1'b1, h, 5, 6'd0, 2);
    rst = 1;
    cycle();
    rst = 0;
    #1;
    reset_checks();
    h = '0; h[31:0] = 32'h0000_0006;
    send_pkt(1'b1, h, 2, 6'd9, 0);
    idle(3);
    chk("t6_cnt2", pkt_cnt[95:64], 32'd1);

    // Randomized traffic with random backpressure and input bubbles
    rdy_mode = 1; bubbles = 1;
    for (int p = 0; p < 40; p++) begin
      send_pkt(1'($urandom_range(0, 3) != 0), rand_hash(), $urandom_range(1, 6), PW'($urandom), 0);
      idle($urandom_range(0, 2));
    end
    rdy_mode = 0;
    idle(5);
    chk("final_drained", ob.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
